multicycle_control_unit: RTL and testbench

Finite-state controller for the multicycle MIPS datapath. Consumes the `opcode` and `function_code` fields produced by the instruction decoder from the instruction register, together with the ALU `zero` flag and a memory-ready handshake. Each cycle it drives the datapath write strobes, mux selects and ALU control. It sits directly downstream of the decoder and sequences every instruction through fetch, decode, execute, memory and write-back.

---
 rtl/multicycle_control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS datapath controller FSM
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  function_code,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_zero,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_ctrl,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic        funct_valid;
    logic [2:0]  funct_alu;

    always_comb begin
        funct_valid = 1'b1;
        funct_alu   = ALU_ADD;
        case (function_code)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        pc_src     = 2'b00;
        alu_ctrl   = ALU_ADD;
        halted     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target precomputed into ALUOut while the opcode is examined.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_HALT: state_d = S_HALT;
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                        state_d    = S_FETCH;
                    end
                    OP_RTYPE: state_d = funct_valid ? S_EXECUTE : S_FETCH;
                    OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
                        state_d = S_EXECUTE;
                    default: state_d = S_FETCH;
                endcase
            end

            S_EXECUTE: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_ctrl = funct_alu;
                        state_d  = S_WRITEBACK;
                    end
                    OP_ADDI: begin
                        alu_src_b = 2'b10;
                        state_d   = S_WRITEBACK;
                    end
                    OP_ORI: begin
                        alu_src_b = 2'b10;
                        ext_zero  = 1'b1;
                        alu_ctrl  = ALU_OR;
                        state_d   = S_WRITEBACK;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = 2'b10;
                        state_d   = S_MEMORY;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_ctrl = ALU_SUB;
                        pc_src   = 2'b01;
                        pc_write = (opcode == OP_BEQ) ? zero : ~zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEMORY: begin
                case (opcode)
                    OP_LW: begin
                        mem_read = 1'b1;
                        if (mem_ready) state_d = S_WRITEBACK;
                    end
                    OP_SW: begin
                        mem_write = 1'b1;
                        if (mem_ready) state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WRITEBACK: begin
                reg_write = 1'b1;
                if (opcode == OP_RTYPE) reg_dst = 2'b01;
                if (opcode == OP_LW) mem_to_reg = 2'b01;
                state_d = S_FETCH;
            end

            S_HALT: halted = 1'b1;

            default: state_d = S_FETCH;
        endcase

        // Reset gates every side effect so an aborted instruction writes nothing.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            halted    = 1'b0;
        end
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (state_q != S_FETCH && state_d == S_FETCH)
            instr_count_d = instr_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  function_code = 6'h20;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic        alu_src_a, ext_zero, halted;
    logic [2:0]  alu_ctrl, state;
    logic [31:0] instr_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count = 32'd0;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .function_code(function_code),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_src(pc_src),
        .alu_ctrl(alu_ctrl), .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Reference: cycles per instruction with no stalls.
    function automatic int base_cycles(input logic [5:0] op, input logic [5:0] fn);
        bit fv = (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
        case (op)
            6'h00:               return fv ? 4 : 2;
            6'h08, 6'h0D, 6'h2B: return 4;
            6'h23:               return 5;
            6'h04, 6'h05:        return 3;
            default:             return 2;
        endcase
    endfunction

    function automatic int exp_reg_writes(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (base_cycles(op, fn) == 4) ? 1 : 0;
        return (op == 6'h08 || op == 6'h0D || op == 6'h23 || op == 6'h03) ? 1 : 0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        opcode = 6'h00;
        function_code = 6'h20;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({pc_write, ir_write, mem_read, mem_write, reg_write, halted} !== 6'b0) begin
                errors++;
                $display("FAIL reset_strobes cyc%0d: got %b expected 000000", i,
                         {pc_write, ir_write, mem_read, mem_write, reg_write, halted});
            end
            checks++;
            if (state !== 3'd0 || instr_count !== 32'd0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got state=%0d count=%0d expected 0/0",
                         i, state, instr_count);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        exp_count = 32'd0;
    endtask

    task automatic test_rtype_add();
        int exp_st[4] = '{0, 1, 2, 4};
        opcode = 6'h00;
        function_code = 6'h20;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (state !== exp_st[k][2:0]) begin
                errors++;
                $display("FAIL add_state k%0d: got %0d expected %0d", k, state, exp_st[k]);
            end
            checks++;
            if (reg_write !== (k == 3)) begin
                errors++;
                $display("FAIL add_reg_write k%0d: got %b expected %b", k, reg_write, k == 3);
            end
            if (k == 3) begin
                checks++;
                if (reg_dst !== 2'b01 || mem_to_reg !== 2'b00) begin
                    errors++;
                    $display("FAIL add_wb_sel: got dst=%b m2r=%b expected 01/00", reg_dst, mem_to_reg);
                end
            end
            next_cycle();
        end
        exp_count++;
        checks++;
        if (state !== 3'd0 || instr_count !== exp_count) begin
            errors++;
            $display("FAIL add_end: got state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_lw_stall();
        int exp_st[7] = '{0, 1, 2, 3, 3, 3, 4};
        opcode = 6'h23;
        mem_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            mem_ready = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (state !== exp_st[k][2:0] ||
                mem_read !== (k == 0 || (k >= 3 && k <= 5))) begin
                errors++;
                $display("FAIL lw_cycle k%0d: got state=%0d mem_read=%b expected %0d/%b", k,
                         state, mem_read, exp_st[k], (k == 0 || (k >= 3 && k <= 5)));
            end
            if (k == 6) begin
                checks++;
                if (reg_write !== 1'b1 || mem_to_reg !== 2'b01 || reg_dst !== 2'b00) begin
                    errors++;
                    $display("FAIL lw_wb: got rw=%b m2r=%b dst=%b expected 1/01/00",
                             reg_write, mem_to_reg, reg_dst);
                end
            end
            next_cycle();
        end
        exp_count++;
        checks++;
        if (state !== 3'd0 || instr_count !== exp_count) begin
            errors++;
            $display("FAIL lw_end: got state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_branch();
        mem_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            opcode = (b < 2) ? 6'h04 : 6'h05;
            zero = (b % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (k == 2) begin
                    checks++;
                    if (state !== 3'd2 || pc_write !== ((opcode == 6'h04) ? zero : !zero) ||
                        pc_src !== 2'b01 || alu_ctrl !== 3'b001) begin
                        errors++;
                        $display("FAIL branch%0d_exec: got st=%0d pcw=%b src=%b alu=%b expected 2/%b/01/001",
                                 b, state, pc_write, pc_src, alu_ctrl, (opcode == 6'h04) ? zero : !zero);
                    end
                end
                next_cycle();
            end
            exp_count++;
            checks++;
            if (state !== 3'd0 || instr_count !== exp_count) begin
                errors++;
                $display("FAIL branch%0d_end: got state=%0d count=%0d expected 0/%0d",
                         b, state, instr_count, exp_count);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        opcode = 6'h03;
        mem_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || pc_write !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 2'b10 ||
            mem_to_reg !== 2'b10 || pc_src !== 2'b10) begin
            errors++;
            $display("FAIL jal_decode: got st=%0d pcw=%b rw=%b dst=%b m2r=%b src=%b expected 1/1/1/10/10/10",
                     state, pc_write, reg_write, reg_dst, mem_to_reg, pc_src);
        end
        next_cycle();
        exp_count++;
        checks++;
        if (state !== 3'd0 || instr_count !== exp_count) begin
            errors++;
            $display("FAIL jal_end: got state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_halt();
        opcode = 6'h3F;
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd5 || halted !== 1'b1 || instr_count !== exp_count ||
                {pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
                errors++;
                $display("FAIL halt_hold k%0d: got st=%0d halted=%b count=%0d strobes=%b expected 5/1/%0d/00000",
                         k, state, halted, instr_count,
                         {pc_write, ir_write, mem_read, mem_write, reg_write}, exp_count);
            end
            next_cycle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || {pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
            errors++;
            $display("FAIL halt_in_reset: got halted=%b strobes=%b expected 0/00000",
                     halted, {pc_write, ir_write, mem_read, mem_write, reg_write});
        end
        next_cycle();
        rst_n = 1'b1;
        opcode = 6'h00;
        function_code = 6'h20;
        exp_count = 32'd0;
        checks++;
        if (state !== 3'd0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL halt_reset: got state=%0d count=%0d expected 0/0", state, instr_count);
        end
    endtask

    task automatic test_nop();
        mem_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            opcode = (n == 0) ? 6'h3E : 6'h00;
            function_code = 6'h00;
            @(negedge clk);
            checks++;
            if (pc_write !== 1'b1 || ir_write !== 1'b1) begin
                errors++;
                $display("FAIL nop%0d_fetch: got pcw=%b irw=%b expected 1/1", n, pc_write, ir_write);
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (state !== 3'd1 || {pc_write, ir_write, mem_write, reg_write} !== 4'b0) begin
                errors++;
                $display("FAIL nop%0d_decode: got st=%0d writes=%b expected 1/0000",
                         n, state, {pc_write, ir_write, mem_write, reg_write});
            end
            next_cycle();
            exp_count++;
        end
        checks++;
        if (state !== 3'd0 || instr_count !== exp_count) begin
            errors++;
            $display("FAIL nop_end: got state=%0d count=%0d expected 0/%0d", state, instr_count, exp_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[13] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B,
                                6'h04, 6'h05, 6'h02, 6'h03, 6'h3E, 6'h11};
        logic [5:0] fns[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h21};
        for (int t = 0; t < 60; t++) begin
            int f, m, n, cnt_pw, cnt_ir, cnt_mr, cnt_mw, cnt_rw;
            int e_pw, e_mr, e_mw;
            bit is_mem;
            opcode = ops[$urandom_range(0, 12)];
            function_code = fns[$urandom_range(0, 6)];
            zero = 1'($urandom_range(0, 1));
            f = $urandom_range(0, 2);
            m = $urandom_range(0, 2);
            is_mem = (opcode == 6'h23 || opcode == 6'h2B);
            n = base_cycles(opcode, function_code) + f + (is_mem ? m : 0);
            cnt_pw = 0; cnt_ir = 0; cnt_mr = 0; cnt_mw = 0; cnt_rw = 0;
            for (int k = 0; k < n; k++) begin
                if (k < f) mem_ready = 1'b0;
                else if (is_mem && k >= f + 3 && k < f + 3 + m) mem_ready = 1'b0;
                else mem_ready = 1'b1;
                @(negedge clk);
                cnt_pw += int'(pc_write);
                cnt_ir += int'(ir_write);
                cnt_mr += int'(mem_read);
                cnt_mw += int'(mem_write);
                cnt_rw += int'(reg_write);
                next_cycle();
            end
            exp_count++;
            e_pw = 1 + ((opcode == 6'h02 || opcode == 6'h03) ? 1 : 0) +
                   (((opcode == 6'h04 && zero) || (opcode == 6'h05 && !zero)) ? 1 : 0);
            e_mr = f + 1 + ((opcode == 6'h23) ? m + 1 : 0);
            e_mw = (opcode == 6'h2B) ? m + 1 : 0;
            checks++;
            if (state !== 3'd0 || instr_count !== exp_count) begin
                errors++;
                $display("FAIL rand%0d_end op=%h fn=%h: got state=%0d count=%0d expected 0/%0d",
                         t, opcode, function_code, state, instr_count, exp_count);
            end
            checks++;
            if (cnt_pw != e_pw || cnt_ir != 1 || cnt_mr != e_mr || cnt_mw != e_mw ||
                cnt_rw != exp_reg_writes(opcode, function_code)) begin
                errors++;
                $display("FAIL rand%0d_strobes op=%h fn=%h z=%b: got pw=%0d ir=%0d mr=%0d mw=%0d rw=%0d expected %0d/1/%0d/%0d/%0d",
                         t, opcode, function_code, zero, cnt_pw, cnt_ir, cnt_mr, cnt_mw, cnt_rw,
                         e_pw, e_mr, e_mw, exp_reg_writes(opcode, function_code));
            end
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_lw_stall();
        test_branch();
        test_jal();
        test_nop();
        test_random();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
